// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding-mode encodings, the FP32
// format and a helper for the packed width of a binary FP word.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;  // round to nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'b01;  // round toward zero
  localparam logic [1:0] RM_RUP = 2'b10;  // round toward +inf
  localparam logic [1:0] RM_RDN = 2'b11;  // round toward -inf

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/int_normalize.sv
// Leading-one detect and left shift: moves the most significant set bit of
// mag to the top of norm and reports its original position p.
module int_normalize #(
  parameter int INT_W = 32,
  parameter int PW    = $clog2(INT_W)
) (
  input  logic [INT_W-1:0] mag,
  output logic [INT_W-1:0] norm,
  output logic [PW-1:0]    p,
  output logic             zero
);

  // Scan upward so the last set bit seen is the leading one.
  always_comb begin
    p    = '0;
    zero = 1'b1;
    for (int i = 0; i < INT_W; i++) begin
      if (mag[i]) begin
        p    = PW'(i);
        zero = 1'b0;
      end
    end
    norm = mag << (INT_W - 1 - int'(p));
  end

endmodule

// File: rtl/int2float_pipe.sv
// Three-stage integer to IEEE-754 converter with valid/ready handshakes.
// Stage 1 takes the magnitude, stage 2 normalises, stage 3 rounds and packs.
// The whole pipe stalls together whenever a result is waiting downstream.
module int2float_pipe
  import fp_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int EXP_W = FP32_EXP_W,
  parameter int MAN_W = FP32_MAN_W,
  parameter int FP_W  = fp_width(EXP_W, MAN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  input  logic             in_signed,
  input  logic [1:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic             out_inexact
);

  localparam int BIAS  = (2 ** (EXP_W - 1)) - 1;
  localparam int PW    = $clog2(INT_W);
  localparam int EXT_W = INT_W + MAN_W + 1;

  // The exponent range must cover every integer magnitude, so no overflow path exists.
  if (INT_W < 2 || INT_W > BIAS) begin : g_param_err
    $error("int2float_pipe: INT_W must lie in [2, 2^(EXP_W-1)-1]");
  end

  // Rounds the normalised magnitude and packs {inexact, sign, exponent, mantissa}.
  function automatic logic [FP_W:0] round_pack(
    input logic             sgn,
    input logic             zro,
    input logic [PW-1:0]    e,
    input logic [INT_W-1:0] nrm,
    input logic [1:0]       rm
  );
    logic [EXT_W-1:0] ext;
    logic [MAN_W-1:0] frac;
    logic             guard, sticky, inexact, up;
    logic [MAN_W:0]   sum;
    logic [EXP_W-1:0] expf;
    if (zro || !nrm[INT_W-1]) return '0;
    // Zero padding below the fraction makes narrow integers exact with no special case.
    ext     = {nrm[INT_W-2:0], {(MAN_W + 2){1'b0}}};
    frac    = ext[EXT_W-1 -: MAN_W];
    guard   = ext[INT_W];
    sticky  = |ext[INT_W-1:0];
    inexact = guard | sticky;
    case (rm)
      RM_RNE:  up = guard & (sticky | frac[0]);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = ~sgn & inexact;
      default: up = sgn & inexact;
    endcase
    sum  = {1'b0, frac} + {{MAN_W{1'b0}}, up};
    expf = EXP_W'(e) + EXP_W'(BIAS) + EXP_W'(sum[MAN_W]);
    return {inexact, sgn, expf, sum[MAN_W-1:0]};
  endfunction

  logic en;

  logic                    vld_p1, vld_p2, vld_p3;
  logic                    sign_p1, sign_p2;
  logic [INT_W-1:0]        mag_p1;
  logic [1:0]              rm_p1, rm_p2;
  logic [INT_W-1:0]        norm_p2;
  logic [PW-1:0]           exp_p2;
  logic                    zero_p2;
  logic [FP_W-1:0]         data_p3;
  logic                    inexact_p3;

  logic signed [INT_W-1:0] data_s;
  logic                    sign_in;
  logic [INT_W-1:0]        mag_in;
  logic [INT_W-1:0]        nrm_norm;
  logic [PW-1:0]           nrm_p;
  logic                    nrm_zero;
  logic [FP_W:0]           rnd;

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign out_valid = vld_p3;
  assign out_data  = data_p3;
  assign out_inexact = inexact_p3;

  assign data_s  = in_data;
  assign sign_in = in_signed & in_data[INT_W-1];
  assign mag_in  = sign_in ? $unsigned(-data_s) : in_data;

  int_normalize #(.INT_W(INT_W), .PW(PW)) u_norm (
    .mag  (mag_p1),
    .norm (nrm_norm),
    .p    (nrm_p),
    .zero (nrm_zero)
  );

  assign rnd = round_pack(sign_p2, zero_p2, exp_p2, norm_p2, rm_p2);

  // Valid bits advance with the shared stall enable; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Stage 1: sign and two's-complement magnitude.
  always_ff @(posedge clk) begin
    if (en) begin
      sign_p1 <= sign_in;
      mag_p1  <= mag_in;
      rm_p1   <= in_rm;
    end
  end

  // Stage 2: leading-one position becomes the unbiased exponent.
  always_ff @(posedge clk) begin
    if (en) begin
      sign_p2 <= sign_p1;
      rm_p2   <= rm_p1;
      norm_p2 <= nrm_norm;
      exp_p2  <= nrm_p;
      zero_p2 <= nrm_zero;
    end
  end

  // Stage 3: rounded result; loaded only for real transactions so idle output stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p3    <= '0;
      inexact_p3 <= 1'b0;
    end else if (en && vld_p2) begin
      data_p3    <= rnd[FP_W-1:0];
      inexact_p3 <= rnd[FP_W];
    end
  end

endmodule
